// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    localparam logic [1:0]  MVHL_LO    = 2'b01;
    localparam logic [1:0]  MVHL_HI    = 2'b10;
    localparam logic [31:0] DIVZERO_LO = '1;

endpackage

// File: rtl/muldiv_if.sv
// EX-stage control/operand bundle between the pipeline and muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic             multordiv;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [1:0]       mvhl;
    logic [WIDTH-1:0] hlout;
    logic             busy;
    logic             hlstall;

    modport master (output start, multordiv, srca, srcb, mvhl,
                    input  hlout, busy, hlstall);
    modport slave  (input  start, multordiv, srca, srcb, mvhl,
                    output hlout, busy, hlstall);
endinterface

// File: rtl/muldiv_datapath.sv
// Combinational iteration step (shift-add multiply / restoring divide) and
// final sign fixup producing HI/LO from the accumulator.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               i_mul,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    input  logic               i_neg,
    input  logic               i_dneg,
    input  logic               i_bzero,
    input  logic [WIDTH-1:0]   i_srca,
    output logic [2*WIDTH-1:0] o_acc_nxt,
    output logic [WIDTH-1:0]   o_hi,
    output logic [WIDTH-1:0]   o_lo
);
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // MULT: acc = {partial product, remaining multiplier bits}, shifted right each step
    assign w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    // DIV: acc = {remainder, dividend bits -> quotient bits}, shifted left each step
    assign w_shl  = i_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff = w_shl - {1'b0, i_opnd};
    assign w_qbit = ~w_diff[WIDTH];

    always_comb begin
        o_acc_nxt = '0;
        if (i_mul)
            o_acc_nxt = {w_sum, i_acc[WIDTH-1:1]};
        else
            o_acc_nxt = {(w_qbit ? w_diff[WIDTH-1:0] : w_shl[WIDTH-1:0]),
                         i_acc[WIDTH-2:0], w_qbit};
    end

    assign w_prod = i_neg ? -i_acc : i_acc;
    assign w_quot = i_acc[WIDTH-1:0];
    assign w_rem  = i_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        o_hi = '0;
        o_lo = '0;
        if (i_mul) begin
            o_hi = w_prod[2*WIDTH-1:WIDTH];
            o_lo = w_prod[WIDTH-1:0];
        end else if (i_bzero) begin
            o_hi = i_srca;
            o_lo = {WIDTH{DIVZERO_LO[0]}};
        end else begin
            o_hi = i_dneg ? -w_rem  : w_rem;
            o_lo = i_neg  ? -w_quot : w_quot;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed MULT/DIV with HI/LO registers and EX-stage stall request.
// Optional MULDIV_FAST_MULT_EN: single-cycle MULT, DIV stays iterative.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    muldiv_state_t      r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd, r_srca, r_hi, r_lo;
    logic               r_mul, r_neg, r_dneg, r_bzero;
    logic               w_launch, w_fast;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_hi, w_lo;
    logic [2*WIDTH-1:0] w_acc_step, w_fast_prod;

    assign w_abs_a = bus.srca[WIDTH-1] ? -bus.srca : bus.srca;
    assign w_abs_b = bus.srcb[WIDTH-1] ? -bus.srcb : bus.srcb;

`ifdef MULDIV_FAST_MULT_EN
    assign w_fast_prod = $signed(bus.srca) * $signed(bus.srcb);
`else
    assign w_fast_prod = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_fast      = 1'b0;
        case (r_state)
            ST_IDLE: if (bus.start) begin
                w_launch = 1'b1;
`ifdef MULDIV_FAST_MULT_EN
                w_fast      = bus.multordiv;
                w_state_nxt = bus.multordiv ? ST_DONE : ST_CALC;
`else
                w_state_nxt = ST_CALC;
`endif
            end
            ST_CALC: if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_srca  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_mul   <= 1'b0;
            r_neg   <= 1'b0;
            r_dneg  <= 1'b0;
            r_bzero <= 1'b0;
        end else if (w_launch) begin
            r_mul   <= bus.multordiv;
            r_dneg  <= bus.srca[WIDTH-1];
            r_srca  <= bus.srca;
            r_bzero <= (bus.srcb == '0);
            r_cnt   <= '0;
            r_opnd  <= bus.multordiv ? w_abs_a : w_abs_b;
            // the fast product is already signed, so the fixup must not negate it
            if (w_fast) begin
                r_acc <= w_fast_prod;
                r_neg <= 1'b0;
            end else begin
                r_acc <= {{WIDTH{1'b0}}, (bus.multordiv ? w_abs_b : w_abs_a)};
                r_neg <= bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1];
            end
        end else if (r_state == ST_CALC) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt + 1'b1;
        end else if (r_state == ST_DONE) begin
            r_hi <= w_hi;
            r_lo <= w_lo;
        end
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .i_mul     (r_mul),
        .i_acc     (r_acc),
        .i_opnd    (r_opnd),
        .i_neg     (r_neg),
        .i_dneg    (r_dneg),
        .i_bzero   (r_bzero),
        .i_srca    (r_srca),
        .o_acc_nxt (w_acc_step),
        .o_hi      (w_hi),
        .o_lo      (w_lo)
    );

    always_comb begin
        bus.hlout = '0;
        if (bus.mvhl == MVHL_HI)      bus.hlout = r_hi;
        else if (bus.mvhl == MVHL_LO) bus.hlout = r_lo;
    end

    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.hlstall = bus.busy & (bus.start | (bus.mvhl != 2'b00));
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // reference state: architectural HI/LO, cycles left busy, pending result
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int m_left = 0;

    function automatic logic [63:0] ref_op(input bit mul, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int sa, sb;
        sa = a;
        sb = b;
        if (mul) begin
            p = longint'(sa) * longint'(sb);
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0; m_hi = '0; m_lo = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (bus.start) begin
            {p_hi, p_lo} = ref_op(bus.multordiv, bus.srca, bus.srcb);
            m_left = bus.multordiv ? MUL_LAT : DIV_LAT;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic        e_busy;
            logic [31:0] e_out;
            e_busy = (m_left > 0);
            e_out  = (bus.mvhl == 2'b10) ? m_hi : (bus.mvhl == 2'b01) ? m_lo : 32'd0;
            check("busy", {31'd0, bus.busy}, {31'd0, e_busy});
            check("hlstall", {31'd0, bus.hlstall},
                  {31'd0, e_busy & (bus.start | (bus.mvhl != 2'b00))});
            check("hlout", bus.hlout, e_out);
        end
    end

    task automatic issue(input bit mul, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.multordiv = mul; bus.srca = a; bus.srcb = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.srca = $urandom; bus.srcb = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) check("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
        bus.mvhl = 2'b10; #1; hi = bus.hlout;
        bus.mvhl = 2'b01; #1; lo = bus.hlout;
        bus.mvhl = 2'b00;
    endtask

    task automatic directed(input string name, input bit mul, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        logic [31:0] hi, lo;
        issue(mul, a, b);
        wait_idle(n);
        check({name, "_lat"}, n, mul ? MUL_LAT : DIV_LAT);
        read_hl(hi, lo);
        check({name, "_hi"}, hi, ehi);
        check({name, "_lo"}, lo, elo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        logic [31:0] hi, lo;
        bus.start = 1'b0; bus.multordiv = 1'b0; bus.srca = '0; bus.srcb = '0; bus.mvhl = 2'b00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cmp_en = 1'b1;

        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_hlstall", {31'd0, bus.hlstall}, 32'd0);
        read_hl(hi, lo);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        directed("mul7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        directed("div-17/5", 1'b0, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        directed("div_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        directed("div42/0", 1'b0, 32'd42, 32'd0, 32'd42, 32'hFFFF_FFFF);
        directed("mul_big", 1'b1, 32'h0001_0000, 32'h0003_0000, 32'd3, 32'd0);

        // MULT followed by MFHI held in EX
        issue(1'b1, 32'h0002_0000, 32'h0004_0000);
        bus.mvhl = 2'b10;
        n = 0;
        while (bus.hlstall && n < 200) begin @(posedge clk); #1; n++; end
        check("mfhi_stall_len", n, MUL_LAT);
        check("mfhi_hlout", bus.hlout, 32'd8);
        bus.mvhl = 2'b00;

        // reset in the middle of a divide
        issue(1'b0, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        read_hl(hi, lo);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        directed("mul2x3", 1'b1, 32'd2, 32'd3, 32'd0, 32'd6);

        // random traffic: starts (some ignored while busy), reads, rare resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset         = ($urandom_range(0, 499) == 0);
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.multordiv = $urandom_range(0, 1);
            bus.srca      = pick();
            bus.srcb      = pick();
            bus.mvhl      = 2'($urandom_range(0, 3));
        end
        @(posedge clk); #1;
        reset = 1'b0; bus.start = 1'b0; bus.mvhl = 2'b00;
        wait_idle(n);
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
